// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the write-back arbiter: priority pointer and grant encoding.
package writeback_arbiter_pkg;

  typedef enum logic {
    PrefAlu = 1'b0,
    PrefLsu = 1'b1
  } prio_e;

  typedef enum logic [1:0] {
    GntNone = 2'd0,
    GntAlu  = 2'd1,
    GntLsu  = 2'd2
  } grant_e;

endpackage

// File: rtl/scoreboard_unit.sv
// Busy-bit scoreboard: one bit per GPR, set on issue, cleared on write-back,
// with two combinational hazard query ports and a sticky double-issue error.
module scoreboard_unit
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned GPR_SIZE       = 5,
  parameter int unsigned NUMBER_OF_GPRS = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                set_valid,
  input  logic [GPR_SIZE-1:0] set_address,
  input  logic                clear_valid,
  input  logic [GPR_SIZE-1:0] clear_address,
  input  logic [GPR_SIZE-1:0] query_address0,
  input  logic [GPR_SIZE-1:0] query_address1,
  output logic                query_busy0,
  output logic                query_busy1,
  output logic                protocol_error
);

  logic [NUMBER_OF_GPRS-1:0] busy_q, busy_d;
  logic                      error_q, error_d;
  logic                      set_target_busy;
  logic                      clear_same;

  always_comb begin
    busy_d          = busy_q;
    set_target_busy = 1'b0;
    query_busy0     = 1'b0;
    query_busy1     = 1'b0;
    for (int i = 0; i < int'(NUMBER_OF_GPRS); i++) begin
      if (clear_valid && (clear_address == GPR_SIZE'(i))) begin
        busy_d[i] = 1'b0;
      end
      // Set applied after clear: a same-cycle issue is younger than the retiring write.
      if (set_valid && (set_address == GPR_SIZE'(i))) begin
        busy_d[i]       = 1'b1;
        set_target_busy = busy_q[i];
      end
      if (query_address0 == GPR_SIZE'(i)) begin
        query_busy0 = busy_q[i];
      end
      if (query_address1 == GPR_SIZE'(i)) begin
        query_busy1 = busy_q[i];
      end
    end
    // A register retiring on this very edge is free for a new issue.
    clear_same = clear_valid && (clear_address == set_address);
    error_d    = error_q | (set_valid & set_target_busy & ~clear_same);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q  <= '0;
      error_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign protocol_error = error_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and LSU,
// with a registered write stage and a busy scoreboard for issue hazard checks.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  // Defaults mirror the architecture header widths.
  parameter int unsigned GPR_SIZE       = 5,
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned NUMBER_OF_GPRS = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [GPR_SIZE-1:0]  alu_address,
  input  logic [DATA_SIZE-1:0] alu_data,
  output logic                 alu_ready,
  input  logic                 lsu_valid,
  input  logic [GPR_SIZE-1:0]  lsu_address,
  input  logic [DATA_SIZE-1:0] lsu_data,
  output logic                 lsu_ready,
  input  logic                 issue_valid,
  input  logic [GPR_SIZE-1:0]  issue_address,
  input  logic [GPR_SIZE-1:0]  query_address0,
  input  logic [GPR_SIZE-1:0]  query_address1,
  output logic                 query_busy0,
  output logic                 query_busy1,
  output logic                 write_enable,
  output logic [GPR_SIZE-1:0]  write_address,
  output logic [DATA_SIZE-1:0] write_data,
  output logic                 protocol_error
);

  prio_e                prio_q, prio_d;
  grant_e               grant;
  logic                 we_q, we_d;
  logic [GPR_SIZE-1:0]  addr_q, addr_d;
  logic [DATA_SIZE-1:0] data_q, data_d;

  always_comb begin
    grant = GntNone;
    if (alu_valid && (!lsu_valid || (prio_q == PrefAlu))) begin
      grant = GntAlu;
    end else if (lsu_valid) begin
      grant = GntLsu;
    end

    prio_d = prio_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    unique case (grant)
      GntAlu: begin
        prio_d = PrefLsu;
        we_d   = 1'b1;
        addr_d = alu_address;
        data_d = alu_data;
      end
      GntLsu: begin
        prio_d = PrefAlu;
        we_d   = 1'b1;
        addr_d = lsu_address;
        data_d = lsu_data;
      end
      default: ;
    endcase
  end

  assign alu_ready = (grant == GntAlu);
  assign lsu_ready = (grant == GntLsu);

  always_ff @(posedge clock) begin
    if (!reset) begin
      prio_q <= PrefAlu;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      prio_q <= prio_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign write_data    = data_q;

  scoreboard_unit #(
    .GPR_SIZE       (GPR_SIZE),
    .NUMBER_OF_GPRS (NUMBER_OF_GPRS)
  ) u_scoreboard (
    .clock          (clock),
    .reset          (reset),
    .set_valid      (issue_valid),
    .set_address    (issue_address),
    .clear_valid    (we_q),
    .clear_address  (addr_q),
    .query_address0 (query_address0),
    .query_address1 (query_address1),
    .query_busy0    (query_busy0),
    .query_busy1    (query_busy1),
    .protocol_error (protocol_error)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge.
module tb_writeback_arbiter;

  localparam int unsigned GprSize  = 5;
  localparam int unsigned DataSize = 32;
  localparam int unsigned NumGprs  = 32;

  logic                clock;
  logic                reset;
  logic                alu_valid, lsu_valid, issue_valid;
  logic [GprSize-1:0]  alu_address, lsu_address, issue_address;
  logic [DataSize-1:0] alu_data, lsu_data;
  logic                alu_ready, lsu_ready;
  logic [GprSize-1:0]  query_address0, query_address1;
  logic                query_busy0, query_busy1;
  logic                write_enable;
  logic [GprSize-1:0]  write_address;
  logic [DataSize-1:0] write_data;
  logic                protocol_error;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_arbiter #(
    .GPR_SIZE       (GprSize),
    .DATA_SIZE      (DataSize),
    .NUMBER_OF_GPRS (NumGprs)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_address    (alu_address),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .lsu_valid      (lsu_valid),
    .lsu_address    (lsu_address),
    .lsu_data       (lsu_data),
    .lsu_ready      (lsu_ready),
    .issue_valid    (issue_valid),
    .issue_address  (issue_address),
    .query_address0 (query_address0),
    .query_address1 (query_address1),
    .query_busy0    (query_busy0),
    .query_busy1    (query_busy1),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .write_data     (write_data),
    .protocol_error (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    alu_valid     = 1'b0;
    alu_address   = '0;
    alu_data      = '0;
    lsu_valid     = 1'b0;
    lsu_address   = '0;
    lsu_data      = '0;
    issue_valid   = 1'b0;
    issue_address = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    query_address0 = '0;
    query_address1 = '0;
    do_reset();

    // Reset state
    query_address0 = 5'd5;
    query_address1 = 5'd5;
    sample();
    check_eq("rst_we", write_enable, 0);
    check_eq("rst_busy_r5", query_busy0, 0);
    check_eq("rst_busy1_r5", query_busy1, 0);
    check_eq("rst_perr", protocol_error, 0);
    check_eq("rst_waddr", write_address, 0);
    check_eq("rst_wdata", write_data, 0);

    // Single ALU write to r3
    step();
    alu_valid   = 1'b1;
    alu_address = 5'd3;
    alu_data    = 32'h0000_00AA;
    sample();
    check_eq("alu_only_ready", alu_ready, 1);
    check_eq("alu_only_lsu_ready", lsu_ready, 0);
    step();
    alu_valid = 1'b0;
    sample();
    check_eq("alu_only_we", write_enable, 1);
    check_eq("alu_only_waddr", write_address, 3);
    check_eq("alu_only_wdata", write_data, 32'hAA);
    step();
    sample();
    check_eq("alu_only_we_drop", write_enable, 0);
    check_eq("alu_only_waddr_hold", write_address, 3);
    check_eq("alu_only_wdata_hold", write_data, 32'hAA);

    // Contention: grants alternate ALU, LSU, ALU, LSU from a fresh reset
    step();
    do_reset();
    alu_valid   = 1'b1;
    alu_address = 5'd1;
    alu_data    = 32'h11;
    lsu_valid   = 1'b1;
    lsu_address = 5'd2;
    lsu_data    = 32'h22;
    for (int i = 0; i < 4; i++) begin
      sample();
      check_eq($sformatf("cont_alu_ready_%0d", i), alu_ready, (i % 2 == 0) ? 1 : 0);
      check_eq($sformatf("cont_lsu_ready_%0d", i), lsu_ready, (i % 2 == 1) ? 1 : 0);
      if (i > 0) begin
        check_eq($sformatf("cont_waddr_%0d", i), write_address, (i % 2 == 1) ? 1 : 2);
        check_eq($sformatf("cont_wdata_%0d", i), write_data, (i % 2 == 1) ? 32'h11 : 32'h22);
      end
      step();
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    sample();
    check_eq("cont_last_we", write_enable, 1);
    check_eq("cont_last_waddr", write_address, 2);
    check_eq("cont_last_wdata", write_data, 32'h22);

    // Scoreboard lifetime for r7
    step();
    do_reset();
    query_address0 = 5'd7;
    query_address1 = 5'd7;
    issue_valid    = 1'b1;
    issue_address  = 5'd7;
    sample();
    check_eq("life_busy_c0", query_busy0, 0);
    step();
    issue_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sample();
      check_eq($sformatf("life_busy_c%0d", c), query_busy0, 1);
      step();
    end
    lsu_valid   = 1'b1;
    lsu_address = 5'd7;
    lsu_data    = 32'h77;
    sample();
    check_eq("life_lsu_ready_c4", lsu_ready, 1);
    check_eq("life_busy_c4", query_busy0, 1);
    step();
    lsu_valid = 1'b0;
    sample();
    check_eq("life_we_c5", write_enable, 1);
    check_eq("life_waddr_c5", write_address, 7);
    check_eq("life_busy_c5", query_busy0, 1);
    step();
    sample();
    check_eq("life_busy_c6", query_busy0, 0);
    check_eq("life_busy1_c6", query_busy1, 0);
    check_eq("life_perr", protocol_error, 0);

    // Same-cycle set and clear on r9
    step();
    query_address0 = 5'd9;
    issue_valid    = 1'b1;
    issue_address  = 5'd9;
    step();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_address = 5'd9;
    alu_data    = 32'h99;
    sample();
    check_eq("same_alu_ready", alu_ready, 1);
    step();
    alu_valid     = 1'b0;
    issue_valid   = 1'b1;
    issue_address = 5'd9;
    sample();
    check_eq("same_we", write_enable, 1);
    check_eq("same_waddr", write_address, 9);
    step();
    issue_valid = 1'b0;
    sample();
    check_eq("same_busy_r9", query_busy0, 1);
    check_eq("same_perr", protocol_error, 0);
    step();
    sample();
    check_eq("same_busy_r9_later", query_busy0, 1);

    // Double issue of r4 with no write-back in between
    step();
    query_address1 = 5'd4;
    issue_valid    = 1'b1;
    issue_address  = 5'd4;
    step();
    sample();
    check_eq("err_busy_r4", query_busy1, 1);
    check_eq("err_before", protocol_error, 0);
    step();
    issue_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check_eq($sformatf("err_sticky_%0d", c), protocol_error, 1);
      step();
    end
    do_reset();
    sample();
    check_eq("err_cleared", protocol_error, 0);

    // Reset while a write to r6 sits in the output register
    step();
    query_address0 = 5'd6;
    issue_valid    = 1'b1;
    issue_address  = 5'd6;
    step();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_address = 5'd6;
    alu_data    = 32'h66;
    sample();
    check_eq("mid_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    reset     = 1'b0;
    sample();
    check_eq("mid_we_pending", write_enable, 1);
    check_eq("mid_busy_pending", query_busy0, 1);
    step();
    reset       = 1'b1;
    alu_valid   = 1'b1;
    alu_address = 5'd1;
    alu_data    = 32'h1;
    lsu_valid   = 1'b1;
    lsu_address = 5'd2;
    lsu_data    = 32'h2;
    sample();
    check_eq("mid_we", write_enable, 0);
    check_eq("mid_waddr", write_address, 0);
    check_eq("mid_wdata", write_data, 0);
    check_eq("mid_busy_r6", query_busy0, 0);
    check_eq("mid_alu_pref", alu_ready, 1);
    check_eq("mid_lsu_wait", lsu_ready, 0);
    step();
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
